// File: rtl/div_unit_pkg.sv
// Shared CPU definitions for the iterative divider: FSM states, iteration count, helpers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package div_unit_pkg;

    // One quotient bit per RUN cycle, so the iteration count equals the operand width.
    localparam int DIV_ITER = 32;
    localparam int CNT_W    = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } divState_t;

    // Two's-complement magnitude. 0x80000000 maps to itself, which still reads
    // correctly as the unsigned value 2^31.
    function automatic logic [31:0] absVal(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_unit_step.sv
// One restoring shift-subtract step of the divider datapath (div_step).
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
// Ports: remIn/quoIn = partial remainder and quotient/dividend shift register,
//        divisor = unsigned divisor magnitude, remOut/quoOut = values after one step.
module div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] remIn,
    input  logic [DATA_W-1:0] quoIn,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] remOut,
    output logic [DATA_W-1:0] quoOut
);

    logic [DATA_W:0] trial;
    logic [DATA_W:0] diff;
    logic            fits;

    always_comb begin
        // Bring the next dividend bit (MSB of the shift register) into the remainder.
        trial  = {remIn, quoIn[DATA_W-1]};
        diff   = trial - {1'b0, divisor};
        fits   = (trial >= {1'b0, divisor});
        // Either result is below the divisor, so it always fits in DATA_W bits.
        remOut = fits ? diff[DATA_W-1:0] : trial[DATA_W-1:0];
        quoOut = {quoIn[DATA_W-2:0], fits};
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit for the Execute stage; remainder to HI, quotient to LO.
// Latency: start sampled in cycle N gives valid_o in cycle N+34 (32 RUN, 1 FIX, DONE).
// Backpressure: stall_o holds Fetch/Decode from the issue cycle until FIX; annul_i aborts.
// Ports: clk/resetn = clock and async active-low reset; start_i/signed_i/dividend_i/
//        divisor_i = instruction issue and operands; annul_i = flush of the Execute slot;
//        stall_o = hazard-unit stall; valid_o/hi_o/lo_o = result for the HI/LO write path.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DATA_W = 32   // only 32 is supported
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start_i,
    input  logic              signed_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    input  logic              annul_i,
    output logic              stall_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    divState_t         stateQ;
    divState_t         stateD;
    logic [CNT_W-1:0]  cntQ;
    logic [DATA_W-1:0] remQ;
    logic [DATA_W-1:0] quoQ;
    logic [DATA_W-1:0] dvsrQ;
    logic              signedQ;
    logic              dvdNegQ;
    logic              dvsNegQ;
    logic              dvsZeroQ;
    logic [DATA_W-1:0] hiQ;
    logic [DATA_W-1:0] loQ;

    logic [DATA_W-1:0] stepRem;
    logic [DATA_W-1:0] stepQuo;
    logic [DATA_W-1:0] fixRem;
    logic [DATA_W-1:0] fixQuo;
    logic              launch;

    assign launch = (stateQ == IDLE) && start_i && !annul_i;

    div_step #(.DATA_W(DATA_W)) u_step (
        .remIn   (remQ),
        .quoIn   (quoQ),
        .divisor (dvsrQ),
        .remOut  (stepRem),
        .quoOut  (stepQuo)
    );

    // Sign correction. A zero divisor forces an all-ones quotient; the remainder
    // path already returns |dividend|, and re-applying the dividend sign restores
    // the original dividend in both modes.
    always_comb begin
        fixRem = (signedQ && dvdNegQ) ? (~remQ + 1'b1) : remQ;
        if (dvsZeroQ) begin
            fixQuo = '1;
        end else if (signedQ && (dvdNegQ ^ dvsNegQ)) begin
            fixQuo = ~quoQ + 1'b1;
        end else begin
            fixQuo = quoQ;
        end
    end

    always_comb begin
        stateD = stateQ;
        case (stateQ)
            IDLE: if (launch) stateD = RUN;
            RUN: begin
                if (annul_i) begin
                    stateD = IDLE;
                end else if (cntQ == CNT_W'(DIV_ITER - 1)) begin
                    stateD = FIX;
                end
            end
            FIX:     stateD = annul_i ? IDLE : DONE;
            DONE:    stateD = IDLE;
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cntQ     <= '0;
            remQ     <= '0;
            quoQ     <= '0;
            dvsrQ    <= '0;
            signedQ  <= 1'b0;
            dvdNegQ  <= 1'b0;
            dvsNegQ  <= 1'b0;
            dvsZeroQ <= 1'b0;
            hiQ      <= '0;
            loQ      <= '0;
        end else begin
            case (stateQ)
                IDLE: begin
                    if (launch) begin
                        cntQ     <= '0;
                        remQ     <= '0;
                        quoQ     <= signed_i ? absVal(dividend_i) : dividend_i;
                        dvsrQ    <= signed_i ? absVal(divisor_i) : divisor_i;
                        signedQ  <= signed_i;
                        dvdNegQ  <= dividend_i[DATA_W-1];
                        dvsNegQ  <= divisor_i[DATA_W-1];
                        dvsZeroQ <= (divisor_i == '0);
                    end
                end
                RUN: begin
                    remQ <= stepRem;
                    quoQ <= stepQuo;
                    cntQ <= cntQ + 1'b1;
                end
                FIX: begin
                    // An annulled instruction must leave HI/LO untouched.
                    if (!annul_i) begin
                        hiQ <= fixRem;
                        loQ <= fixQuo;
                    end
                end
                default: ;
            endcase
        end
    end

    // Combinational so Decode stalls in the issue cycle; gated by resetn so the
    // stall drops immediately while reset is held.
    assign stall_o = resetn && (launch || (stateQ == RUN) || (stateQ == FIX));
    assign valid_o = (stateQ == DONE);
    assign hi_o    = hiQ;
    assign lo_o    = loQ;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start_i;
    logic        signed_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        annul_i;
    logic        stall_o;
    logic        valid_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    div_unit #(.DATA_W(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start_i    (start_i),
        .signed_i   (signed_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .annul_i    (annul_i),
        .stall_o    (stall_o),
        .valid_o    (valid_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Inputs change and outputs are sampled 2 time units after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reference: MIPS-style truncating division; divide-by-zero yields all-ones / dividend.
    function automatic void refDiv(input logic s, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] q, output logic [31:0] r);
        longint sa;
        longint sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Full operation from IDLE with cycle-exact stall/valid checks.
    // holdStart keeps start_i high (with scrambled operands) through the DONE cycle.
    task automatic runOp(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input bit holdStart, input string name);
        logic [31:0] expQ;
        logic [31:0] expR;
        int          badCyc;
        refDiv(s, a, b, expQ, expR);
        badCyc     = -1;
        start_i    = 1'b1;
        signed_i   = s;
        dividend_i = a;
        divisor_i  = b;
        annul_i    = 1'b0;
        #1;
        checks++;
        if (stall_o !== 1'b1 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL %s issue: stall=%b valid=%b, required stall=1 valid=0", name, stall_o, valid_o);
        end
        for (int k = 1; k <= 34; k++) begin
            tick();
            if (holdStart) begin
                dividend_i = $urandom;
                divisor_i  = $urandom;
                signed_i   = ~signed_i;
            end else begin
                start_i = 1'b0;
            end
            #1;
            if (k < 34) begin
                if ((stall_o !== 1'b1 || valid_o !== 1'b0) && badCyc < 0) badCyc = k;
            end else begin
                checks++;
                if (valid_o !== 1'b1 || stall_o !== 1'b0) begin
                    errors++;
                    $display("FAIL %s done: valid=%b stall=%b at N+34, required valid=1 stall=0", name, valid_o, stall_o);
                end
                checks++;
                if (lo_o !== expQ || hi_o !== expR) begin
                    errors++;
                    $display("FAIL %s result: lo=%h hi=%h, required lo=%h hi=%h", name, lo_o, hi_o, expQ, expR);
                end
            end
        end
        checks++;
        if (badCyc >= 0) begin
            errors++;
            $display("FAIL %s busy: stall/valid wrong first at cycle N+%0d, required stall=1 valid=0", name, badCyc);
        end
        tick();
        start_i = 1'b0;
        #1;
        checks++;
        if (valid_o !== 1'b0 || stall_o !== 1'b0 || lo_o !== expQ || hi_o !== expR) begin
            errors++;
            $display("FAIL %s after: valid=%b stall=%b lo=%h hi=%h, required 0 0 lo=%h hi=%h",
                     name, valid_o, stall_o, lo_o, hi_o, expQ, expR);
        end
    endtask

    // Watch for any valid_o over n cycles; one check.
    task automatic expectQuiet(input int n, input string name);
        int seen;
        seen = 0;
        for (int k = 0; k < n; k++) begin
            tick();
            if (valid_o === 1'b1 || stall_o === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL %s quiet: %0d busy/valid cycles seen, required 0", name, seen);
        end
    endtask

    task automatic test_reset();
        resetn     = 1'b0;
        start_i    = 1'b1;
        signed_i   = 1'b0;
        dividend_i = 32'd9;
        divisor_i  = 32'd3;
        annul_i    = 1'b0;
        tick();
        tick();
        checks++;
        if (stall_o !== 1'b0 || valid_o !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd0) begin
            errors++;
            $display("FAIL reset: stall=%b valid=%b hi=%h lo=%h, required all 0", stall_o, valid_o, hi_o, lo_o);
        end
        start_i = 1'b0;
        tick();
        resetn = 1'b1;
    endtask

    task automatic test_directed();
        runOp(1'b0, 32'd100, 32'd7, 1'b0, "divu_100_7");
        runOp(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_m7_2");
        runOp(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0, "div_7_m2");
        runOp(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_overflow");
        runOp(1'b0, 32'd5, 32'd0, 1'b0, "divu_by_zero");
        runOp(1'b1, 32'hFFFF_FFF0, 32'd0, 1'b0, "div_neg_by_zero");
        runOp(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, "divu_max_1");
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        for (int i = 0; i < 20; i++) begin
            s = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : 32'($urandom);
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = -32'($urandom_range(1, 15));
                default: b = 32'($urandom);
            endcase
            runOp(s, a, b, 1'b0, "random");
        end
    endtask

    // Abort at a given cycle after issue (11 = RUN iteration 10, 33 = FIX).
    task automatic test_annul(input int at, input string name);
        logic [31:0] prevHi;
        logic [31:0] prevLo;
        prevHi     = hi_o;
        prevLo     = lo_o;
        start_i    = 1'b1;
        signed_i   = 1'b0;
        dividend_i = 32'd12345;
        divisor_i  = 32'd77;
        for (int k = 1; k <= at; k++) begin
            tick();
            start_i = 1'b0;
        end
        annul_i = 1'b1;
        #1;
        checks++;
        if (stall_o !== 1'b1) begin
            errors++;
            $display("FAIL %s busy: stall=%b before annul edge, required 1", name, stall_o);
        end
        tick();
        annul_i = 1'b0;
        #1;
        checks++;
        if (stall_o !== 1'b0 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL %s idle: stall=%b valid=%b after annul, required 0 0", name, stall_o, valid_o);
        end
        expectQuiet(40, name);
        checks++;
        if (hi_o !== prevHi || lo_o !== prevLo) begin
            errors++;
            $display("FAIL %s retain: hi=%h lo=%h, required hi=%h lo=%h", name, hi_o, lo_o, prevHi, prevLo);
        end
        runOp(1'b1, 32'hFFFF_FF00, 32'd9, 1'b0, "after_annul");
    endtask

    task automatic test_start_annul_idle();
        start_i    = 1'b1;
        annul_i    = 1'b1;
        signed_i   = 1'b0;
        dividend_i = 32'd50;
        divisor_i  = 32'd5;
        #1;
        checks++;
        if (stall_o !== 1'b0) begin
            errors++;
            $display("FAIL start_annul stall: stall=%b, required 0", stall_o);
        end
        tick();
        start_i = 1'b0;
        annul_i = 1'b0;
        expectQuiet(40, "start_annul");
    endtask

    task automatic test_reset_mid();
        start_i    = 1'b1;
        signed_i   = 1'b1;
        dividend_i = 32'hFFFF_1234;
        divisor_i  = 32'd13;
        for (int k = 1; k <= 21; k++) begin
            tick();
            start_i = 1'b0;
        end
        resetn = 1'b0;
        #1;
        checks++;
        if (stall_o !== 1'b0 || valid_o !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid: stall=%b valid=%b hi=%h lo=%h, required all 0", stall_o, valid_o, hi_o, lo_o);
        end
        tick();
        tick();
        resetn = 1'b1;
        runOp(1'b1, 32'hFFFF_1234, 32'd13, 1'b0, "after_reset");
    endtask

    task automatic test_back_to_back();
        runOp(1'b0, 32'd1000, 32'd33, 1'b1, "hold_start");
        expectQuiet(40, "hold_start");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_annul(11, "annul_run");
        test_annul(33, "annul_fix");
        test_start_annul_idle();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
